// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from vga_sync_gen to pattern generators and sync pins.
// frame_cnt_o exists only when VGA_SYNC_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
    logic [9:0]  column_o;
    logic [9:0]  row_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        visible_o;
    logic        line_start_o;
    logic        frame_start_o;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_o;
`endif

    modport master (
        output column_o, row_o, hsync_o, vsync_o, visible_o, line_start_o, frame_start_o
`ifdef VGA_SYNC_FRAME_CNT_EN
        , output frame_cnt_o
`endif
    );

    modport slave (
        input column_o, row_o, hsync_o, vsync_o, visible_o, line_start_o, frame_start_o
`ifdef VGA_SYNC_FRAME_CNT_EN
        , input frame_cnt_o
`endif
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing: column/row counters advanced by pix_en_i, with zero-latency decoded
// active-low syncs, visible flag and start strobes. VGA_SYNC_FRAME_CNT_EN adds a frame counter.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en_i,
    vga_sync_gen_if.master sync_if
);
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_LO = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC;
    localparam int V_SYNC_LO = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       frame_wrap;

    assign frame_wrap = pix_en_i && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_i) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sync_if.frame_cnt_o = frame_cnt_q;
`else
    logic unused_frame_wrap;
    assign unused_frame_wrap = frame_wrap;
`endif

    // Sync windows compared as int so a window ending exactly at 1024 still decodes.
    assign sync_if.column_o      = h_cnt_q;
    assign sync_if.row_o         = v_cnt_q;
    assign sync_if.hsync_o       = !((int'(h_cnt_q) >= H_SYNC_LO) && (int'(h_cnt_q) < H_SYNC_HI));
    assign sync_if.vsync_o       = !((int'(v_cnt_q) >= V_SYNC_LO) && (int'(v_cnt_q) < V_SYNC_HI));
    assign sync_if.visible_o     = (int'(h_cnt_q) < H_VISIBLE) && (int'(v_cnt_q) < V_VISIBLE);
    assign sync_if.line_start_o  = !reset && pix_en_i && (h_cnt_q == '0);
    assign sync_if.frame_start_o = !reset && pix_en_i && (h_cnt_q == '0) && (v_cnt_q == '0);
endmodule
